// File: rtl/spi_slave_if.sv
// SPI slave pin and byte-stream bundle: serial pins toward the master, tx/rx
// byte handshakes toward the local logic.
interface spi_slave_if;
  logic       cs_n;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       underrun;

  modport slave (
    input  cs_n, sck, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
  );

  modport master (
    output cs_n, sck, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
  );
endinterface

// File: rtl/spi_slave.sv
// Oversampled SPI slave (sck idle low, MSB first): miso changes on sck rise,
// mosi is sampled on sck fall, with a one-byte transmit holding buffer.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       rst,
  spi_slave_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic [2:0]             bit_cnt;
  logic [7:0]             tx_shift;
  logic [7:0]             rx_shift;
  logic [7:0]             buf_data;
  logic                   buf_full;
  logic [7:0]             rx_data_r;
  logic                   rx_valid_r;
  logic                   underrun_r;

  logic cs_s, sck_s, mosi_s;
  logic sck_rise, sck_fall;
  logic selected;
  logic buf_load, buf_consume;

  always_comb begin
    cs_s        = cs_sync[SYNC_STAGES-1];
    sck_s       = sck_sync[SYNC_STAGES-1];
    mosi_s      = mosi_sync[SYNC_STAGES-1];
    sck_rise    = sck_s & ~sck_d;
    sck_fall    = ~sck_s & sck_d;
    // Edges only count while selected and not in the deselect cycle itself.
    selected    = (state == ACTIVE) && !cs_s;
    buf_load    = bus.tx_valid && !buf_full;
    buf_consume = selected && sck_rise && (bit_cnt == 3'd0) && buf_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cs_sync    <= '1;
      sck_sync   <= '0;
      mosi_sync  <= '0;
      sck_d      <= 1'b0;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      buf_data   <= '0;
      buf_full   <= 1'b0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_d      <= sck_s;
      rx_valid_r <= 1'b0;
      underrun_r <= 1'b0;

      // A load wins over a consume so the buffer ends full with the new byte.
      if (buf_load) begin
        buf_data <= bus.tx_data;
        buf_full <= 1'b1;
      end else if (buf_consume) begin
        buf_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!cs_s) state <= ACTIVE;
        end
        ACTIVE: begin
          if (cs_s) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
          end else begin
            if (sck_rise) begin
              if (bit_cnt == 3'd0) begin
                if (buf_full) begin
                  tx_shift <= buf_data;
                end else begin
                  tx_shift   <= '0;
                  underrun_r <= 1'b1;
                end
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
            if (sck_fall) begin
              rx_shift <= {rx_shift[6:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data_r  <= {rx_shift[6:0], mosi_s};
                rx_valid_r <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.miso     = (state == ACTIVE) & tx_shift[7];
  assign bus.miso_oe  = (state == ACTIVE);
  assign bus.busy     = (state == ACTIVE);
  assign bus.tx_ready = ~buf_full;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.underrun = underrun_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: master pins driven at clk:sck = 8, byte-level
// results checked against hand-computed values.
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rxv_cnt = 0;
  int   ur_cnt = 0;
  logic [7:0] rx_hist [0:63];

  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_hist[rxv_cnt[5:0]] = bus.rx_data;
      rxv_cnt++;
    end
    if (bus.underrun === 1'b1) ur_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic cs_low;
    @(negedge clk);
    bus.cs_n = 1'b0;
    wait_clks(4);
  endtask

  task automatic cs_high;
    @(negedge clk);
    bus.cs_n = 1'b1;
    wait_clks(6);
  endtask

  // Sends the first n bits of mo MSB first; miso is sampled just before each fall.
  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.mosi = mo[7-i];
      bus.sck  = 1'b1;
      wait_clks(4);
      mi[7-i]  = bus.miso;
      bus.sck  = 1'b0;
      wait_clks(3);
    end
  endtask

  task automatic test_reset;
    wait_clks(3);
    n_cmp++;
    if ({bus.miso, bus.miso_oe, bus.busy, bus.tx_ready, bus.rx_valid, bus.underrun} !== 6'b000100) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 000100",
               {bus.miso, bus.miso_oe, bus.busy, bus.tx_ready, bus.rx_valid, bus.underrun});
    end
    n_cmp++;
    if (bus.rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_rx_data: got %h required 00", bus.rx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_clks(4);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_busy: got %b required 0", bus.busy);
    end
  endtask

  task automatic test_single_byte;
    logic [7:0] mi;
    int rx0, ur0;
    rx0 = rxv_cnt; ur0 = ur_cnt;
    push_tx(8'hA5);
    n_cmp++;
    if (bus.tx_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_tx_ready_full: got %b required 0", bus.tx_ready);
    end
    cs_low();
    n_cmp++;
    if ({bus.busy, bus.miso_oe} !== 2'b11) begin
      n_err++;
      $display("FAIL single_busy_oe: got %b required 11", {bus.busy, bus.miso_oe});
    end
    spi_bits(8'h3C, 8, mi);
    wait_clks(2);
    n_cmp++;
    if (mi !== 8'hA5) begin
      n_err++;
      $display("FAIL single_miso: got %h required a5", mi);
    end
    n_cmp++;
    if (bus.rx_data !== 8'h3C) begin
      n_err++;
      $display("FAIL single_rx_data: got %h required 3c", bus.rx_data);
    end
    n_cmp++;
    if (rxv_cnt - rx0 != 1) begin
      n_err++;
      $display("FAIL single_rx_valid_count: got %0d required 1", rxv_cnt - rx0);
    end
    n_cmp++;
    if ({ur_cnt - ur0, bus.tx_ready} !== {32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL single_underrun_ready: got ur=%0d ready=%b required ur=0 ready=1",
               ur_cnt - ur0, bus.tx_ready);
    end
    cs_high();
    n_cmp++;
    if ({bus.busy, bus.miso_oe, bus.miso} !== 3'b000) begin
      n_err++;
      $display("FAIL single_deselect: got %b required 000", {bus.busy, bus.miso_oe, bus.miso});
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] mi0, mi1;
    int rx0;
    int waited;
    rx0 = rxv_cnt;
    push_tx(8'h01);
    cs_low();
    fork
      spi_bits(8'hFF, 8, mi0);
      begin
        waited = 0;
        while (bus.tx_ready !== 1'b1 && waited < 100) begin
          @(negedge clk);
          waited++;
        end
        n_cmp++;
        if (bus.tx_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_tx_ready_rise: got %b required 1", bus.tx_ready);
        end
        push_tx(8'h80);
      end
    join
    spi_bits(8'h00, 8, mi1);
    wait_clks(2);
    cs_high();
    n_cmp++;
    if ({mi0, mi1} !== 16'h0180) begin
      n_err++;
      $display("FAIL b2b_miso: got %h required 0180", {mi0, mi1});
    end
    n_cmp++;
    if (rxv_cnt - rx0 != 2) begin
      n_err++;
      $display("FAIL b2b_rx_valid_count: got %0d required 2", rxv_cnt - rx0);
    end else begin
      n_cmp++;
      if ({rx_hist[rx0[5:0]], rx_hist[rx0[5:0] + 6'd1]} !== 16'hFF00) begin
        n_err++;
        $display("FAIL b2b_rx_bytes: got %h%h required ff00",
                 rx_hist[rx0[5:0]], rx_hist[rx0[5:0] + 6'd1]);
      end
    end
  endtask

  task automatic test_underrun;
    logic [7:0] mi;
    int rx0, ur0;
    rx0 = rxv_cnt; ur0 = ur_cnt;
    cs_low();
    spi_bits(8'h55, 8, mi);
    wait_clks(2);
    cs_high();
    n_cmp++;
    if (mi !== 8'h00) begin
      n_err++;
      $display("FAIL underrun_miso: got %h required 00", mi);
    end
    n_cmp++;
    if (ur_cnt - ur0 != 1) begin
      n_err++;
      $display("FAIL underrun_pulses: got %0d required 1", ur_cnt - ur0);
    end
    n_cmp++;
    if (bus.rx_data !== 8'h55 || rxv_cnt - rx0 != 1) begin
      n_err++;
      $display("FAIL underrun_rx: got %h/%0d required 55/1", bus.rx_data, rxv_cnt - rx0);
    end
  endtask

  task automatic test_abort;
    logic [7:0] mi;
    int rx0;
    rx0 = rxv_cnt;
    cs_low();
    spi_bits(8'hF0, 5, mi);
    cs_high();
    n_cmp++;
    if (rxv_cnt - rx0 != 0) begin
      n_err++;
      $display("FAIL abort_no_rx_valid: got %0d required 0", rxv_cnt - rx0);
    end
    n_cmp++;
    if (bus.rx_data !== 8'h55) begin
      n_err++;
      $display("FAIL abort_rx_data_held: got %h required 55", bus.rx_data);
    end
    cs_low();
    spi_bits(8'hC3, 8, mi);
    wait_clks(2);
    cs_high();
    n_cmp++;
    if (bus.rx_data !== 8'hC3 || rxv_cnt - rx0 != 1) begin
      n_err++;
      $display("FAIL abort_next_byte: got %h/%0d required c3/1", bus.rx_data, rxv_cnt - rx0);
    end
  endtask

  task automatic test_idle_ignore;
    logic [7:0] mi;
    int rx0;
    logic oe_seen;
    rx0 = rxv_cnt;
    oe_seen = 1'b0;
    push_tx(8'hAB);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.mosi = i[0];
      bus.sck  = 1'b1;
      wait_clks(4);
      oe_seen |= bus.miso_oe;
      bus.sck  = 1'b0;
      wait_clks(4);
      oe_seen |= bus.miso_oe;
    end
    n_cmp++;
    if (rxv_cnt - rx0 != 0 || oe_seen !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ignore_rx_oe: got rxv=%0d oe=%b required rxv=0 oe=0", rxv_cnt - rx0, oe_seen);
    end
    n_cmp++;
    if (bus.tx_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ignore_buffer: got tx_ready %b required 0", bus.tx_ready);
    end
    cs_low();
    spi_bits(8'h5A, 8, mi);
    wait_clks(2);
    cs_high();
    n_cmp++;
    if ({mi, bus.rx_data} !== 16'hAB5A) begin
      n_err++;
      $display("FAIL idle_ignore_followup: got %h required ab5a", {mi, bus.rx_data});
    end
  endtask

  task automatic test_reset_mid_byte;
    logic [7:0] mi;
    int rx0;
    rx0 = rxv_cnt;
    push_tx(8'h11);
    cs_low();
    spi_bits(8'hE7, 3, mi);
    push_tx(8'h22);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.miso, bus.miso_oe, bus.busy, bus.tx_ready, bus.rx_valid, bus.underrun} !== 6'b000100) begin
      n_err++;
      $display("FAIL rstmid_flags: got %b required 000100",
               {bus.miso, bus.miso_oe, bus.busy, bus.tx_ready, bus.rx_valid, bus.underrun});
    end
    n_cmp++;
    if (bus.rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_rx_data: got %h required 00", bus.rx_data);
    end
    rst = 1'b0;
    bus.cs_n = 1'b1;
    wait_clks(6);
    n_cmp++;
    if (rxv_cnt - rx0 != 0) begin
      n_err++;
      $display("FAIL rstmid_no_rx_valid: got %0d required 0", rxv_cnt - rx0);
    end
    push_tx(8'h96);
    cs_low();
    spi_bits(8'h69, 8, mi);
    wait_clks(2);
    cs_high();
    n_cmp++;
    if ({mi, bus.rx_data} !== 16'h9669 || rxv_cnt - rx0 != 1) begin
      n_err++;
      $display("FAIL rstmid_followup: got %h/%0d required 9669/1", {mi, bus.rx_data}, rxv_cnt - rx0);
    end
  endtask

  initial begin
    bus.cs_n     = 1'b1;
    bus.sck      = 1'b0;
    bus.mosi     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_idle_ignore();
    test_reset_mid_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for cs_n/sck/mosi (legal ≥2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high; clock clk.
REQ-004 SHALL have port cs_n  input  1  chip select from master, active-low, asynchronous to clk.
REQ-005 SHALL have port sck  input  1  SPI clock from master, idle low, asynchronous to clk.
REQ-006 SHALL have port mosi  input  1  serial data from master, MSB first.
REQ-007 SHALL have port miso  output  1  serial data to master, MSB first.
REQ-008 SHALL have port miso_oe  output  1  tristate enable for miso pad; high while selected.
REQ-009 SHALL have port tx_data  input  8  next byte to transmit.
REQ-010 SHALL have port tx_valid  input  1  tx_data valid; transfer when tx_valid && tx_ready.
REQ-011 SHALL have port tx_ready  output  1  transmit holding buffer empty.
REQ-012 SHALL have port rx_data  output  8  last complete received byte.
REQ-013 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-014 SHALL have port busy  output  1  high while synchronized cs_n low.
REQ-015 SHALL have port underrun  output  1  one-cycle pulse, byte started with empty buffer.

Function
REQ-016 SHALL pass cs_n, sck, mosi each through SYNC_STAGES flops; cs_n sync flops reset to 1, others to 0.
REQ-017 SHALL detect sck rise/fall by comparing last sync stage with a one-cycle-delayed copy; edge acts on the clk cycle it is detected.
REQ-018 SHALL require clk ≥ 8× sck frequency; behaviour at lower ratios is undefined.
REQ-019 SHALL implement states IDLE (cs_n_s=1) and ACTIVE (cs_n_s=0); IDLE->ACTIVE on cs_n_s fall, ACTIVE->IDLE on cs_n_s rise.
REQ-020 SHALL in IDLE hold 3-bit bit counter at 0, ignore sck edges, drive miso 0 and miso_oe 0.
REQ-021 SHALL drive busy and miso_oe equal to (state == ACTIVE).
REQ-022 SHALL on each sck rise in ACTIVE with bit counter 0 load tx shift register from holding buffer (buffer becomes empty) if full, else load 8'h00 and pulse underrun next cycle.
REQ-023 SHALL drive miso from tx shift register bit 7; on sck rise with bit counter ≠0 shift tx register left by one, filling 0.
REQ-024 SHALL on each sck fall in ACTIVE shift synchronized mosi into rx shift register LSB and increment bit counter modulo 8.
REQ-025 SHALL on the sck fall where bit counter wraps 7->0 write the completed byte to rx_data and assert rx_valid for exactly the following clk cycle.
REQ-026 SHALL support back-to-back bytes within one cs_n assertion without gaps; the 9th rise starts the next byte per REQ-022.
REQ-027 SHALL drive tx_ready = ~buffer_full; buffer loads on tx_valid && tx_ready; load and shift-register consume in the same cycle are both honoured (buffer ends full with new data).
REQ-028 SHALL on cs_n_s rise mid-byte abort: bit counter to 0, rx shift register discarded, no rx_valid; holding buffer content retained.
REQ-029 SHALL hold rx_data until the next completed byte.

Reset
REQ-030 SHALL on rst: state IDLE, bit counter 0, shift registers 0, buffer empty, rx_data 8'h00, rx_valid 0, underrun 0, miso 0, miso_oe 0, busy 0, tx_ready 1.
REQ-031 SHALL apply rst regardless of cs_n level; a transfer in progress is aborted without rx_valid.

Verification
REQ-032 SHALL verify single byte: preload tx 8'hA5, master sends 8'h3C (clk:sck=8) -> miso sequence 1,0,1,0,0,1,0,1; rx_data=8'h3C, one rx_valid pulse.
REQ-033 SHALL verify back-to-back: preload 8'h01, reload 8'h80 after tx_ready rises, master sends 8'hFF,8'h00 in one cs_n -> miso bytes 01,80; two rx_valid with FF then 00.
REQ-034 SHALL verify underrun: buffer empty, master sends 8'h55 -> miso all 0, underrun one pulse, rx_data=8'h55.
REQ-035 SHALL verify abort: cs_n raised after 5 sck falls -> no rx_valid, rx_data unchanged, next full byte received correctly.
REQ-036 SHALL verify reset mid-byte: rst after 3 bits -> all outputs at REQ-030 values next cycle; following transfer correct.
REQ-037 SHALL verify idle ignore: sck toggled with cs_n=1 -> no rx_valid, miso_oe=0, buffer unchanged.
